// File: rtl/synth_cdc_responder_if.sv
// rtl/synth_cdc_responder_if.sv - CPU->synth configuration handshake and bundle interface
interface synth_cdc_responder_if #(
    parameter int N_VOICES = 1
);
    logic                   req_async;
    logic                   ack;
    logic                   update;
    logic [24*N_VOICES-1:0] cpu_carrier_fcws;
    logic [23:0]            cpu_mod_fcw;
    logic [4:0]             cpu_mod_shift;
    logic [N_VOICES-1:0]    cpu_note_en;
    logic [4:0]             cpu_synth_shift;
    logic [24*N_VOICES-1:0] synth_carrier_fcws;
    logic [23:0]            synth_mod_fcw;
    logic [4:0]             synth_mod_shift;
    logic [N_VOICES-1:0]    synth_note_en;
    logic [4:0]             synth_synth_shift;

    // CPU side: raises req with a stable bundle, watches ack and the captured copy
    modport master (
        output req_async,
        output cpu_carrier_fcws,
        output cpu_mod_fcw,
        output cpu_mod_shift,
        output cpu_note_en,
        output cpu_synth_shift,
        input  ack,
        input  update,
        input  synth_carrier_fcws,
        input  synth_mod_fcw,
        input  synth_mod_shift,
        input  synth_note_en,
        input  synth_synth_shift
    );

    // Synth side: the responder
    modport slave (
        input  req_async,
        input  cpu_carrier_fcws,
        input  cpu_mod_fcw,
        input  cpu_mod_shift,
        input  cpu_note_en,
        input  cpu_synth_shift,
        output ack,
        output update,
        output synth_carrier_fcws,
        output synth_mod_fcw,
        output synth_mod_shift,
        output synth_note_en,
        output synth_synth_shift
    );
endinterface

// File: rtl/synth_cdc_responder.sv
// rtl/synth_cdc_responder.sv - synth-domain end of the four-phase config transfer (optional SYNTH_CDC_XFER_COUNT_EN)
module synth_cdc_responder #(
    parameter int N_VOICES    = 1,
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    synth_cdc_responder_if.slave      bus
`ifdef SYNTH_CDC_XFER_COUNT_EN
    ,
    output logic [15:0]               xfer_count
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   ack_q, ack_d;
    logic                   update_q;
    logic                   load;

    logic [24*N_VOICES-1:0] carrier_fcws_q;
    logic [23:0]            mod_fcw_q;
    logic [4:0]             mod_shift_q;
    logic [N_VOICES-1:0]    note_en_q;
    logic [4:0]             synth_shift_q;

    // Only req crosses through a synchronizer; the bundle is held stable by the protocol
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.req_async};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Next state: capture once on req rise, release ack once req is seen low
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    load    = 1'b1;
                    ack_d   = 1'b1;
                    state_d = ACKED;
                end
            end
            ACKED: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    // State, ack and update flops; update can only follow an IDLE cycle so it never repeats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ack_q    <= 1'b0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            update_q <= load;
        end
    end

    // Whole bundle loads on one edge so downstream never sees a partial update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carrier_fcws_q <= '0;
            mod_fcw_q      <= '0;
            mod_shift_q    <= '0;
            note_en_q      <= '0;
            synth_shift_q  <= '0;
        end else if (load) begin
            carrier_fcws_q <= bus.cpu_carrier_fcws;
            mod_fcw_q      <= bus.cpu_mod_fcw;
            mod_shift_q    <= bus.cpu_mod_shift;
            note_en_q      <= bus.cpu_note_en;
            synth_shift_q  <= bus.cpu_synth_shift;
        end
    end

    assign bus.ack                = ack_q;
    assign bus.update             = update_q;
    assign bus.synth_carrier_fcws = carrier_fcws_q;
    assign bus.synth_mod_fcw      = mod_fcw_q;
    assign bus.synth_mod_shift    = mod_shift_q;
    assign bus.synth_note_en      = note_en_q;
    assign bus.synth_synth_shift  = synth_shift_q;

`ifdef SYNTH_CDC_XFER_COUNT_EN
    logic [15:0] xfer_cnt_q;

    // Saturating transfer counter, advanced by each update pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= '0;
        end else if (update_q && (xfer_cnt_q != 16'hFFFF)) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_count = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_synth_cdc_responder.sv
// tb/tb_synth_cdc_responder.sv - directed self-checking bench for synth_cdc_responder
module tb_synth_cdc_responder;

    localparam int N_VOICES    = 1;
    localparam int SYNC_STAGES = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;
    int   upd_cnt = 0;
    int   dbl_cnt = 0;
    logic prev_upd = 1'b0;
    int   base;

    synth_cdc_responder_if #(.N_VOICES(N_VOICES)) bus ();

`ifdef SYNTH_CDC_XFER_COUNT_EN
    logic [15:0] xfer_count;
`endif

    synth_cdc_responder #(
        .N_VOICES   (N_VOICES),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef SYNTH_CDC_XFER_COUNT_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    always #5 clk = ~clk;

    // Count update pulses and back-to-back highs, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.update === 1'b1) upd_cnt++;
        if (bus.update === 1'b1 && prev_upd === 1'b1) dbl_cnt++;
        prev_upd = bus.update;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v);
        for (int n = 0; n < 12 && bus.ack !== v; n++) tick();
        check("ack_wait", 64'(bus.ack), 64'(v));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ack"}, 64'(bus.ack), 64'h0);
        check({tag, "_upd"}, 64'(bus.update), 64'h0);
        check({tag, "_car"}, 64'(bus.synth_carrier_fcws), 64'h0);
        check({tag, "_mfcw"}, 64'(bus.synth_mod_fcw), 64'h0);
        check({tag, "_mshf"}, 64'(bus.synth_mod_shift), 64'h0);
        check({tag, "_nen"}, 64'(bus.synth_note_en), 64'h0);
        check({tag, "_sshf"}, 64'(bus.synth_synth_shift), 64'h0);
    endtask

    initial begin
        // Test 1: reset held with req high and nonzero bundle
        rst_n                = 1'b0;
        bus.req_async        = 1'b1;
        bus.cpu_carrier_fcws = 24'hFFFFFF;
        bus.cpu_mod_fcw      = 24'h123456;
        bus.cpu_mod_shift    = 5'd9;
        bus.cpu_note_en      = 1'b1;
        bus.cpu_synth_shift  = 5'd4;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_zero("rst_hold");
            tick();
        end
`ifdef SYNTH_CDC_XFER_COUNT_EN
        check("rst_xfer", 64'(xfer_count), 64'h0);
`endif
        bus.req_async = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Glitch shorter than a clock period between edges is filtered
        base = upd_cnt;
        bus.req_async = 1'b1;
        #2;
        bus.req_async = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("glitch_ack", 64'(bus.ack), 64'h0);
        check("glitch_upd", 64'(upd_cnt - base), 64'h0);

        // Test 2: latency of capture and ack
        base = upd_cnt;
        bus.cpu_carrier_fcws = 24'h001234;
        bus.cpu_mod_fcw      = 24'h000456;
        bus.cpu_mod_shift    = 5'd3;
        bus.cpu_note_en      = 1'b1;
        bus.cpu_synth_shift  = 5'd2;
        bus.req_async        = 1'b1;
        tick();
        check("lat_e0_ack", 64'(bus.ack), 64'h0);
        tick();
        check("lat_e1_ack", 64'(bus.ack), 64'h0);
        check("lat_e1_mfcw", 64'(bus.synth_mod_fcw), 64'h0);
        tick();
        check("lat_e2_ack", 64'(bus.ack), 64'h1);
        check("lat_e2_upd", 64'(bus.update), 64'h1);
        check("lat_e2_car", 64'(bus.synth_carrier_fcws), 64'h001234);
        check("lat_e2_mfcw", 64'(bus.synth_mod_fcw), 64'h000456);
        check("lat_e2_mshf", 64'(bus.synth_mod_shift), 64'h3);
        check("lat_e2_nen", 64'(bus.synth_note_en), 64'h1);
        check("lat_e2_sshf", 64'(bus.synth_synth_shift), 64'h2);

        // Test 3: bundle changes while ACKED are ignored
        bus.cpu_mod_fcw = 24'hABCDEF;
        tick();
        check("upd_one_cycle", 64'(bus.update), 64'h0);
        for (int i = 0; i < 4; i++) tick();
        check("hold_mfcw", 64'(bus.synth_mod_fcw), 64'h000456);
        check("single_upd", 64'(upd_cnt - base), 64'h1);
        check("hold_ack", 64'(bus.ack), 64'h1);

        // Falling req: ack drops on the third edge
        bus.req_async = 1'b0;
        tick();
        check("fall_e0_ack", 64'(bus.ack), 64'h1);
        tick();
        check("fall_e1_ack", 64'(bus.ack), 64'h1);
        tick();
        check("fall_e2_ack", 64'(bus.ack), 64'h0);
        check("fall_mfcw", 64'(bus.synth_mod_fcw), 64'h000456);

        // Test 4: four back-to-back handshakes
        base = upd_cnt;
        for (int i = 1; i <= 4; i++) begin
            bus.cpu_mod_shift = 5'(i);
            bus.req_async     = 1'b1;
            wait_ack(1'b1);
            check("b2b_mshf", 64'(bus.synth_mod_shift), 64'(i));
            bus.req_async = 1'b0;
            wait_ack(1'b0);
        end
        check("b2b_upd_cnt", 64'(upd_cnt - base), 64'h4);
        check("b2b_no_double", 64'(dbl_cnt), 64'h0);

        // Test 5: reset while ACKED with req held high
        bus.cpu_mod_shift = 5'd7;
        bus.cpu_mod_fcw   = 24'h0000AA;
        bus.req_async     = 1'b1;
        wait_ack(1'b1);
        check("pre_rst_mfcw", 64'(bus.synth_mod_fcw), 64'h0000AA);
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        tick();
        tick();
        check_zero("mid_rst2");
        rst_n = 1'b1;
        tick();
        check("rel_e0_ack", 64'(bus.ack), 64'h0);
        tick();
        check("rel_e1_ack", 64'(bus.ack), 64'h0);
        tick();
        check("rel_e2_ack", 64'(bus.ack), 64'h1);
        check("rel_e2_upd", 64'(bus.update), 64'h1);
        check("rel_e2_mshf", 64'(bus.synth_mod_shift), 64'h7);
        check("rel_e2_mfcw", 64'(bus.synth_mod_fcw), 64'h0000AA);
        bus.req_async = 1'b0;
        wait_ack(1'b0);

`ifdef SYNTH_CDC_XFER_COUNT_EN
        // Test 6: counter saturates at FFFF
        force dut.xfer_cnt_q = 16'hFFFD;
        tick();
        release dut.xfer_cnt_q;
        bus.req_async = 1'b1;
        wait_ack(1'b1);
        tick();
        check("xfer_fffe", 64'(xfer_count), 64'hFFFE);
        bus.req_async = 1'b0;
        wait_ack(1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.req_async = 1'b1;
            wait_ack(1'b1);
            bus.req_async = 1'b0;
            wait_ack(1'b0);
        end
        check("xfer_sat", 64'(xfer_count), 64'hFFFF);
`endif

        check("final_no_double", 64'(dbl_cnt), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
